// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: instruction width, NOP encoding, fetch FSM states, buffer entry.
package cpu_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

   typedef enum logic {
      FS_RUN   = 1'b0,
      FS_DRAIN = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and memory.
interface fetch_unit_if;
   import cpu_pkg::*;

   logic            imem_req_o;
   logic [XLEN-1:0] imem_addr_o;
   logic            imem_gnt_i;
   logic            imem_rvalid_i;
   logic [XLEN-1:0] imem_rdata_i;

   modport master (
      output imem_req_o,
      output imem_addr_o,
      input  imem_gnt_i,
      input  imem_rvalid_i,
      input  imem_rdata_i
   );

   modport slave (
      input  imem_req_o,
      input  imem_addr_o,
      output imem_gnt_i,
      output imem_rvalid_i,
      output imem_rdata_i
   );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, instr} entries with clear; DEPTH must be a power of two.
module fetch_fifo
   import cpu_pkg::*;
#(
   parameter  int unsigned DEPTH = 2,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic             clear_i,
   input  fetch_entry_t     wdata_i,
   output fetch_entry_t     rdata_o,
   output logic [CNT_W-1:0] count_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   fetch_entry_t     mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count_nxt;
   logic             do_push;
   logic             do_pop;

   assign do_push   = push_i & ~full_o;
   assign do_pop    = pop_i & ~empty_o;
   assign count_nxt = count_o + CNT_W'(do_push) - CNT_W'(do_pop);
   assign rdata_o   = mem[rd_ptr];

   // Pointers, occupancy and registered full/empty flags.
   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_o <= '0;
         full_o  <= 1'b0;
         empty_o <= 1'b1;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count_o <= count_nxt;
         full_o  <= (count_nxt == CNT_W'(DEPTH));
         empty_o <= (count_nxt == '0);
      end
   end

   // Entry storage; contents need no reset since occupancy gates every read.
   always_ff @(posedge clk_i) begin
      if (do_push) mem[wr_ptr] <= wdata_i;
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited requests, in-order responses, IF/ID register, redirect drain.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned     BUF_DEPTH = 2
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            stall_i,
   input  logic            flush_i,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   fetch_unit_if.master    imem,
   output logic [XLEN-1:0] instr_o,
   output logic [XLEN-1:0] pc_o,
   output logic            instr_valid_o
);

   localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

   fetch_state_e     state;
   logic [XLEN-1:0]  fetch_pc;
   logic [CNT_W-1:0] outstanding;
   logic [CNT_W-1:0] drop_cnt;
   logic [CNT_W-1:0] in_flight;
   logic [CNT_W-1:0] buf_count;
   logic [CNT_W:0]   credit_used;
   logic             buf_full;
   logic             buf_empty;
   logic             buf_push;
   logic             buf_pop;
   logic             grant;
   logic             rsp_accept;
   logic             use_bypass;
   fetch_entry_t     buf_head;
   fetch_entry_t     rsp_entry;

   // Credit covers every request not yet popped, stale ones included.
   assign credit_used      = (CNT_W+1)'(outstanding) + (CNT_W+1)'(buf_count);
   assign imem.imem_req_o  = ~rst_i & ~redirect_i & ~buf_full
                           & (credit_used < (CNT_W+1)'(BUF_DEPTH));
   assign imem.imem_addr_o = fetch_pc;
   assign grant            = imem.imem_req_o & imem.imem_gnt_i;

   // In RUN every outstanding request is on the current path, so the oldest one
   // sits outstanding words behind fetch_pc.
   assign rsp_accept      = imem.imem_rvalid_i & ~rst_i & ~redirect_i & (state == FS_RUN);
   assign rsp_entry.pc    = fetch_pc - (XLEN'(outstanding) << 2);
   assign rsp_entry.instr = imem.imem_rdata_i;
   assign in_flight       = outstanding - CNT_W'(imem.imem_rvalid_i);

   assign buf_pop    = ~rst_i & ~stall_i & ~flush_i & ~redirect_i & ~buf_empty;
   assign use_bypass = ~stall_i & ~flush_i & buf_empty & rsp_accept;
   assign buf_push   = rsp_accept & ~use_bypass;

   fetch_fifo #(
      .DEPTH (BUF_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (buf_push),
      .pop_i   (buf_pop),
      .clear_i (redirect_i),
      .wdata_i (rsp_entry),
      .rdata_o (buf_head),
      .count_o (buf_count),
      .full_o  (buf_full),
      .empty_o (buf_empty)
   );

   // Fetch PC, outstanding counter and RUN/DRAIN tracking of stale responses.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= FS_RUN;
         fetch_pc    <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
      end else begin
         outstanding <= outstanding + CNT_W'(grant) - CNT_W'(imem.imem_rvalid_i);
         if (redirect_i)  fetch_pc <= redirect_pc_i;
         else if (grant)  fetch_pc <= fetch_pc + XLEN'(4);
         case (state)
            FS_RUN: begin
               if (redirect_i && (in_flight != '0)) begin
                  state    <= FS_DRAIN;
                  drop_cnt <= in_flight;
               end
            end
            FS_DRAIN: begin
               if (redirect_i) begin
                  drop_cnt <= in_flight;
                  if (in_flight == '0) state <= FS_RUN;
               end else if (imem.imem_rvalid_i) begin
                  drop_cnt <= drop_cnt - CNT_W'(1);
                  if (drop_cnt == CNT_W'(1)) state <= FS_RUN;
               end
            end
            default: state <= FS_RUN;
         endcase
      end
   end

   // IF/ID register: stall holds, flush/redirect bubble, else buffer head, bypass, or bubble.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         instr_o       <= NOP_INSTR;
         pc_o          <= RESET_PC;
         instr_valid_o <= 1'b0;
      end else if (!stall_i) begin
         if (flush_i || redirect_i) begin
            instr_o       <= NOP_INSTR;
            instr_valid_o <= 1'b0;
         end else if (!buf_empty) begin
            instr_o       <= buf_head.instr;
            pc_o          <= buf_head.pc;
            instr_valid_o <= 1'b1;
         end else if (rsp_accept) begin
            instr_o       <= rsp_entry.instr;
            pc_o          <= rsp_entry.pc;
            instr_valid_o <= 1'b1;
         end else begin
            instr_o       <= NOP_INSTR;
            instr_valid_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a queue-based reference model and an in-order memory model.
module tb_fetch_unit;
   import cpu_pkg::*;

   localparam int unsigned DEPTH = 2;

   logic clk;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst, stall, flush, redir;
   logic [31:0]     rpc;
   logic [31:0]     instr, pc;
   logic            valid;
   logic [31:0]     w_instr, w_pc;
   logic            w_valid;
   logic            zero;

   fetch_unit_if imem ();
   fetch_unit_if wmem ();

   fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(DEPTH)) u_dut (
      .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
      .redirect_i(redir), .redirect_pc_i(rpc), .imem(imem),
      .instr_o(instr), .pc_o(pc), .instr_valid_o(valid)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .BUF_DEPTH(DEPTH)) u_wrap (
      .clk_i(clk), .rst_i(rst), .stall_i(zero), .flush_i(zero),
      .redirect_i(zero), .redirect_pc_i(32'h0), .imem(wmem),
      .instr_o(w_instr), .pc_o(w_pc), .instr_valid_o(w_valid)
   );

   typedef struct { logic [31:0] pc; bit stale; } fl_t;
   typedef struct { logic [31:0] addr; int due; } mq_t;

   fl_t          inflight[$];
   fetch_entry_t mbuf[$];
   mq_t          mem_q[$];
   logic [31:0]  m_fpc, m_instr, m_pc;
   logic         m_valid;
   bit           m_known;
   int           cyc, mem_lat, last_due;
   int           errors, checks;
   logic         obs_req;
   logic [31:0]  obs_addr;
   logic         w_req_q;
   logic [31:0]  w_addr_q;

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return a ^ 32'h5A5A_0003;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock cycle: drive inputs, compare DUT against the model at negedge, advance model and memory.
   task automatic cycle(input bit r, input bit s, input bit f, input bit rd, input logic [31:0] rp);
      logic         m_req;
      bit           acc;
      fl_t          fl;
      fetch_entry_t e, h;
      int           due;
      rst = r; stall = s; flush = f; redir = rd; rpc = rp;
      imem.imem_gnt_i = 1'b1;
      if (!r && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
         imem.imem_rvalid_i = 1'b1;
         imem.imem_rdata_i  = word_of(mem_q[0].addr);
      end else begin
         imem.imem_rvalid_i = 1'b0;
         imem.imem_rdata_i  = 32'h0;
      end
      wmem.imem_gnt_i    = 1'b1;
      wmem.imem_rvalid_i = w_req_q & ~r;
      wmem.imem_rdata_i  = word_of(w_addr_q);
      @(negedge clk);
      m_req = !r && !rd && (inflight.size() + mbuf.size() < DEPTH);
      chk("imem_req", 32'(imem.imem_req_o), 32'(m_req));
      if (m_req) chk("imem_addr", imem.imem_addr_o, m_fpc);
      if (m_known) begin
         chk("instr_o", instr, m_instr);
         chk("pc_o", pc, m_pc);
         chk("instr_valid_o", 32'(valid), 32'(m_valid));
      end
      obs_req  = imem.imem_req_o;
      obs_addr = imem.imem_addr_o;
      if (r) begin
         inflight.delete(); mbuf.delete();
         m_fpc = 32'h0; m_instr = NOP_INSTR; m_pc = 32'h0; m_valid = 1'b0; m_known = 1'b1;
      end else begin
         acc = 1'b0;
         e.pc = 32'h0; e.instr = 32'h0;
         if (imem.imem_rvalid_i && inflight.size() > 0) begin
            fl = inflight.pop_front();
            acc = !fl.stale && !rd;
            e.pc = fl.pc; e.instr = imem.imem_rdata_i;
         end
         if (rd) begin
            foreach (inflight[i]) inflight[i].stale = 1'b1;
            mbuf.delete();
            m_fpc = rp;
         end else if (m_req) begin
            inflight.push_back('{m_fpc, 1'b0});
            m_fpc = m_fpc + 32'd4;
         end
         if (s) begin
            if (acc) mbuf.push_back(e);
         end else if (f || rd) begin
            m_instr = NOP_INSTR; m_valid = 1'b0;
            if (acc) mbuf.push_back(e);
         end else if (mbuf.size() > 0) begin
            h = mbuf.pop_front();
            m_pc = h.pc; m_instr = h.instr; m_valid = 1'b1;
            if (acc) mbuf.push_back(e);
         end else if (acc) begin
            m_pc = e.pc; m_instr = e.instr; m_valid = 1'b1;
         end else begin
            m_instr = NOP_INSTR; m_valid = 1'b0;
         end
      end
      if (r) begin
         mem_q.delete();
         last_due = cyc;
      end else begin
         if (imem.imem_rvalid_i) void'(mem_q.pop_front());
         if (imem.imem_req_o && imem.imem_gnt_i) begin
            due = cyc + mem_lat;
            if (due <= last_due) due = last_due + 1;
            mem_q.push_back('{imem.imem_addr_o, due});
            last_due = due;
         end
      end
      w_req_q  = wmem.imem_req_o & ~r;
      w_addr_q = wmem.imem_addr_o;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
   endtask

   initial begin
      logic [31:0] exp_pc;
      int          nval;
      bit          found, seen_req;
      errors = 0; checks = 0; cyc = 0; mem_lat = 1; last_due = 0; m_known = 1'b0;
      w_req_q = 1'b0; w_addr_q = 32'h0; zero = 1'b0;
      rst = 1'b1; stall = 1'b0; flush = 1'b0; redir = 1'b0; rpc = 32'h0;
      imem.imem_gnt_i = 1'b0; imem.imem_rvalid_i = 1'b0; imem.imem_rdata_i = 32'h0;
      wmem.imem_gnt_i = 1'b0; wmem.imem_rvalid_i = 1'b0; wmem.imem_rdata_i = 32'h0;
      @(posedge clk);
      #1;

      // Reset, first fetches with 1-cycle memory, and wrap-around instance.
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'h40);
      chk("reset instr_o", instr, 32'h0000_0000);
      chk("reset pc_o", pc, 32'h0000_0000);
      chk("reset valid", 32'(valid), 32'h0);
      chk("reset wrap pc_o", w_pc, 32'hFFFF_FFFC);
      run(1);
      chk("first req", 32'(obs_req), 32'h1);
      chk("first addr", obs_addr, 32'h0);
      chk("no valid 1 cycle after reset", 32'(valid), 32'h0);
      run(1);
      chk("second addr", obs_addr, 32'h4);
      chk("first valid", 32'(valid), 32'h1);
      chk("first pc_o", pc, 32'h0);
      chk("first instr_o", instr, 32'h5A5A_0003);
      chk("wrap first pc_o", w_pc, 32'hFFFF_FFFC);
      chk("wrap first valid", 32'(w_valid), 32'h1);
      run(1);
      chk("third addr", obs_addr, 32'h8);
      chk("second pc_o", pc, 32'h4);
      chk("wrap second pc_o", w_pc, 32'h0000_0000);
      chk("wrap second instr_o", w_instr, 32'h5A5A_0003);

      // Stall for three cycles while responses keep arriving.
      run(1);
      chk("pre-stall pc_o", pc, 32'h8);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
         chk("stall hold pc_o", pc, 32'h8);
         chk("stall hold instr_o", instr, word_of(32'h8));
         chk("stall credit", 32'(mem_q.size() <= DEPTH), 32'h1);
      end
      exp_pc = 32'd12; nval = 0;
      for (int i = 0; i < 10; i++) begin
         run(1);
         if (valid) begin
            chk("post-stall pc sequence", pc, exp_pc);
            exp_pc = exp_pc + 32'd4;
            nval++;
         end
      end
      chk("post-stall progress", 32'(nval >= 6), 32'h1);

      // Latency 3, redirect to 0x100 with two requests in flight.
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      mem_lat = 3;
      for (int i = 0; i < 2; i++) begin
         run(1);
         chk("lat3 pre-redirect bubble", 32'(valid), 32'h0);
      end
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h100);
      chk("lat3 redirect bubble", 32'(valid), 32'h0);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         run(1);
         if (valid) begin
            found = 1'b1;
            chk("lat3 first valid pc_o", pc, 32'h100);
            chk("lat3 first valid instr_o", instr, word_of(32'h100));
         end
      end
      chk("lat3 reached valid", 32'(found), 32'h1);

      // Redirect with a same-cycle response, then a second redirect while draining.
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      mem_lat = 3; run(1);
      mem_lat = 5; run(1);
      mem_lat = 2; run(1);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h80);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h200);
      found = 1'b0; seen_req = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         run(1);
         if (obs_req && !seen_req) begin
            seen_req = 1'b1;
            chk("double redirect first addr", obs_addr, 32'h200);
         end
         if (valid) begin
            found = 1'b1;
            chk("double redirect first pc_o", pc, 32'h200);
         end
      end
      chk("double redirect reached valid", 32'(found), 32'h1);

      // Stall+flush together, then flush alone, then buffered words drain in order.
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      mem_lat = 1;
      run(4);
      chk("sf pre pc_o", pc, 32'h8);
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      chk("stall+flush hold pc_o", pc, 32'h8);
      chk("stall+flush hold valid", 32'(valid), 32'h1);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      chk("flush bubble valid", 32'(valid), 32'h0);
      chk("flush bubble instr_o", instr, NOP_INSTR);
      chk("flush bubble pc_o", pc, 32'h8);
      run(1);
      chk("after flush pc_o", pc, 32'hC);
      chk("after flush valid", 32'(valid), 32'h1);
      run(1);
      chk("after flush next pc_o", pc, 32'h10);
      run(3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
